// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC, imem req/ack master and IF/ID register.
// Latency: ack in cycle N shows up in IF/ID in N+1; zero-wait memory sustains 1 instr/cycle.
// Backpressure: stall holds IF/ID; a fetch colliding with stall is skidded (FETCH_SKID_BUFFER_EN) or refetched.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic        func7b5
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_RESET   = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] req_addr;
    logic [31:0] pend_target;
    logic [31:0] target_aligned;

`ifdef FETCH_SKID_BUFFER_EN
    logic        skid_vld;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
`endif

    logic        load_en;
    logic [31:0] load_instr;
    logic [31:0] load_pc;

    assign target_aligned = redirect_target & 32'hFFFF_FFFC;
    assign imem_addr      = req_addr;
    assign id_pc_plus4    = id_pc + 32'd4;
    assign opcode         = id_instr[6:0];
    assign func3          = id_instr[14:12];
    assign func7b5        = id_instr[30];

    // Select what, if anything, IF/ID would take this cycle (fresh memory data or the skid entry).
    always_comb begin
        load_en    = 1'b0;
        load_instr = imem_rdata;
        load_pc    = req_addr;
        if (state == S_FETCH && imem_ack && !redirect && !stall) begin
            load_en = 1'b1;
        end
`ifdef FETCH_SKID_BUFFER_EN
        else if (state == S_HOLD && skid_vld && !redirect && !stall) begin
            load_en    = 1'b1;
            load_instr = skid_instr;
            load_pc    = skid_pc;
        end
`endif
    end

    // Fetch FSM: owns the request line, the fetch address, the pending redirect target and the skid entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_RESET;
            imem_req    <= 1'b0;
            req_addr    <= RESET_PC;
            pend_target <= 32'h0;
`ifdef FETCH_SKID_BUFFER_EN
            skid_vld    <= 1'b0;
            skid_instr  <= NOP;
            skid_pc     <= 32'h0;
`endif
        end else begin
            case (state)
                S_RESET: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            req_addr <= target_aligned;
                        end else if (!stall) begin
                            req_addr <= req_addr + 32'd4;
                        end else begin
                            // ID is full: park the response (or drop it and refetch later)
                            state    <= S_HOLD;
                            imem_req <= 1'b0;
`ifdef FETCH_SKID_BUFFER_EN
                            skid_vld   <= 1'b1;
                            skid_instr <= imem_rdata;
                            skid_pc    <= req_addr;
`endif
                        end
                    end else if (redirect) begin
                        // request already on the bus must complete before the address may move
                        pend_target <= target_aligned;
                        state       <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (imem_ack) begin
                        req_addr <= redirect ? target_aligned : pend_target;
                        state    <= S_FETCH;
                    end else if (redirect) begin
                        pend_target <= target_aligned;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        req_addr <= target_aligned;
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
`ifdef FETCH_SKID_BUFFER_EN
                        skid_vld <= 1'b0;
`endif
                    end else if (!stall) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
`ifdef FETCH_SKID_BUFFER_EN
                        // skid entry moves into IF/ID this edge, so continue with the next word
                        if (skid_vld) begin
                            req_addr <= req_addr + 32'd4;
                        end
                        skid_vld <= 1'b0;
`endif
                    end
                end
                default: begin
                    state    <= S_RESET;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID register: redirect flushes, stall holds, otherwise load new instruction or insert a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
            id_instr <= NOP;
            id_pc    <= 32'h0;
        end else if (redirect) begin
            id_valid <= 1'b0;
        end else if (!stall) begin
            if (load_en) begin
                id_valid <= 1'b1;
                id_instr <= load_instr;
                id_pc    <= load_pc;
            end else begin
                id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch traffic against a program-order reference model plus timed expectations.
// Memory model answers word reads with configurable or random wait states.
// A monitor on the falling edge pops and compares all expectations; stimulus only pushes them.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam int K_REQ   = 0;
    localparam int K_ADDR  = 1;
    localparam int K_VLD   = 2;
    localparam int K_PC    = 3;
    localparam int K_INSTR = 4;
    localparam int K_OPC   = 5;
    localparam int K_F3    = 6;
    localparam int K_F7    = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        func7b5;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .id_valid        (id_valid),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc_plus4),
        .opcode          (opcode),
        .func3           (func3),
        .func7b5         (func7b5)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory contents: one special word for decode checks, otherwise addr|0x13.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'h40B5_0533 : (a | 32'h13);
    endfunction

    // Memory responder: picks a wait count per request, acks combinationally when it reaches zero.
    int lat_fix  = 0;
    bit lat_rand = 1'b0;
    int mcnt     = 0;
    bit mfresh   = 1'b1;
    always @(posedge clk) begin
        #2;
        if (!imem_req) begin
            imem_ack = 1'b0;
            mfresh   = 1'b1;
        end else begin
            if (mfresh) begin
                mcnt   = lat_rand ? int'($urandom_range(0, 3)) : lat_fix;
                mfresh = 1'b0;
            end
            if (mcnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                mfresh     = 1'b1;
            end else begin
                imem_ack = 1'b0;
                mcnt--;
            end
        end
    end

    // Scoreboard storage
    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t        eq[$];
    logic [31:0] rq[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic expect_at(input int c, input int k, input logic [31:0] v);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        eq.push_back(e);
    endtask

    function automatic logic [31:0] probe(input int k);
        case (k)
            K_REQ:   return {31'h0, imem_req};
            K_ADDR:  return imem_addr;
            K_VLD:   return {31'h0, id_valid};
            K_PC:    return id_pc;
            K_INSTR: return id_instr;
            K_OPC:   return {25'h0, opcode};
            K_F3:    return {29'h0, func3};
            default: return {31'h0, func7b5};
        endcase
    endfunction

    function automatic string kname(input int k);
        case (k)
            K_REQ:   return "imem_req";
            K_ADDR:  return "imem_addr";
            K_VLD:   return "id_valid";
            K_PC:    return "id_pc";
            K_INSTR: return "id_instr";
            K_OPC:   return "opcode";
            K_F3:    return "func3";
            default: return "func7b5";
        endcase
    endfunction

    // Monitor: timed expectations, program-order model of consumed instructions, bus protocol.
    logic [31:0] nxt_pc   = RESET_PC;
    int          consumed = 0;
    bit          p_rst    = 1'b0;
    bit          p_req    = 1'b0;
    bit          p_ack    = 1'b0;
    logic [31:0] p_addr   = 32'h0;
    exp_t        me;
    always @(negedge clk) begin
        while (eq.size() > 0 && eq[0].cyc <= cyc) begin
            me = eq.pop_front();
            if (me.cyc == cyc) check(kname(me.kind), probe(me.kind), me.val);
            else               check("late_expectation", me.cyc, cyc);
        end
        if (!rst_n) begin
            nxt_pc = RESET_PC;
            rq.delete();
        end else begin
            if (id_valid && !stall) begin
                check("id_pc_program_order", id_pc, nxt_pc);
                check("id_instr_data", id_instr, mem_word(id_pc));
                nxt_pc = id_pc + 32'd4;
                consumed++;
            end
            if (redirect) begin
                if (rq.size() > 0) nxt_pc = rq.pop_front();
                else check("redirect_queue_empty", 32'h0, 32'h1);
            end
            if (id_valid) begin
                check("id_pc_plus4", id_pc_plus4, id_pc + 32'd4);
                check("opcode_field", {25'h0, opcode}, {25'h0, id_instr[6:0]});
                check("func3_field", {29'h0, func3}, {29'h0, id_instr[14:12]});
                check("func7b5_field", {31'h0, func7b5}, {31'h0, id_instr[30]});
            end
            if (p_rst && p_req && !p_ack) begin
                check("req_held_until_ack", {31'h0, imem_req}, 32'h1);
                check("addr_stable_until_ack", imem_addr, p_addr);
            end
        end
        p_rst  = rst_n;
        p_req  = imem_req;
        p_ack  = imem_ack;
        p_addr = imem_addr;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic issue_redirect(input logic [31:0] t);
        redirect        = 1'b1;
        redirect_target = t;
        rq.push_back(t & 32'hFFFF_FFFC);
    endtask

    // Stimulus
    int          c0;
    logic [31:0] t;
    initial begin
        // Reset values, zero-wait streaming and a 3-cycle stall colliding with the ack of 0x8
        lat_fix = 0;
        do_reset();
        c0 = cyc;
        expect_at(c0, K_REQ, 0);   expect_at(c0, K_ADDR, RESET_PC);
        expect_at(c0, K_VLD, 0);   expect_at(c0, K_INSTR, 32'h13);
        expect_at(c0, K_PC, 0);
        expect_at(c0 + 1, K_REQ, 1); expect_at(c0 + 1, K_ADDR, 32'h0);
        expect_at(c0 + 2, K_REQ, 1); expect_at(c0 + 2, K_ADDR, 32'h4);
        expect_at(c0 + 2, K_VLD, 1); expect_at(c0 + 2, K_PC, 32'h0);
        expect_at(c0 + 2, K_INSTR, 32'h13);
        expect_at(c0 + 3, K_REQ, 1); expect_at(c0 + 3, K_ADDR, 32'h8);
        expect_at(c0 + 3, K_VLD, 1); expect_at(c0 + 3, K_PC, 32'h4);
        for (int k = 4; k <= 6; k++) begin
            expect_at(c0 + k, K_REQ, 0);
            expect_at(c0 + k, K_VLD, 1);
            expect_at(c0 + k, K_PC, 32'h4);
        end
`ifdef FETCH_SKID_BUFFER_EN
        expect_at(c0 + 7, K_VLD, 1);   expect_at(c0 + 7, K_PC, 32'h8);
        expect_at(c0 + 7, K_REQ, 1);   expect_at(c0 + 7, K_ADDR, 32'hC);
`else
        expect_at(c0 + 7, K_REQ, 1);   expect_at(c0 + 7, K_ADDR, 32'h8);
        expect_at(c0 + 7, K_VLD, 0);
        expect_at(c0 + 8, K_VLD, 1);   expect_at(c0 + 8, K_PC, 32'h8);
`endif
        repeat (3) step();
        stall = 1'b1;
        repeat (3) step();
        stall = 1'b0;
        repeat (4) step();

        // One wait state, redirect to 0x40 while 0x8 is outstanding
        lat_fix = 1;
        do_reset();
        c0 = cyc;
        expect_at(c0 + 5, K_REQ, 1);   expect_at(c0 + 5, K_ADDR, 32'h8);
        expect_at(c0 + 5, K_VLD, 1);   expect_at(c0 + 5, K_PC, 32'h4);
        expect_at(c0 + 6, K_VLD, 0);   expect_at(c0 + 6, K_REQ, 1);
        expect_at(c0 + 6, K_ADDR, 32'h8);
        expect_at(c0 + 7, K_REQ, 1);   expect_at(c0 + 7, K_ADDR, 32'h40);
        expect_at(c0 + 7, K_VLD, 0);
        expect_at(c0 + 8, K_VLD, 0);   expect_at(c0 + 8, K_ADDR, 32'h40);
        expect_at(c0 + 9, K_VLD, 1);   expect_at(c0 + 9, K_PC, 32'h40);
        expect_at(c0 + 9, K_INSTR, 32'h53);
        repeat (5) step();
        issue_redirect(32'h40);
        step();
        redirect = 1'b0;
        repeat (5) step();

        // Zero-wait: redirect+stall together, then an unaligned redirect onto the decode word
        lat_fix = 0;
        do_reset();
        c0 = cyc;
        expect_at(c0 + 2, K_VLD, 1);   expect_at(c0 + 2, K_PC, 32'h0);
        expect_at(c0 + 3, K_VLD, 0);   expect_at(c0 + 3, K_REQ, 1);
        expect_at(c0 + 3, K_ADDR, 32'h80);
        expect_at(c0 + 4, K_VLD, 1);   expect_at(c0 + 4, K_PC, 32'h80);
        expect_at(c0 + 4, K_INSTR, 32'h93);
        expect_at(c0 + 5, K_ADDR, 32'h100); expect_at(c0 + 5, K_VLD, 0);
        expect_at(c0 + 6, K_VLD, 1);   expect_at(c0 + 6, K_PC, 32'h100);
        expect_at(c0 + 6, K_INSTR, 32'h40B5_0533);
        expect_at(c0 + 6, K_OPC, 32'h33);
        expect_at(c0 + 6, K_F3, 32'h0);
        expect_at(c0 + 6, K_F7, 32'h1);
        repeat (2) step();
        stall = 1'b1;
        issue_redirect(32'h80);
        step();
        stall    = 1'b0;
        redirect = 1'b0;
        step();
        issue_redirect(32'h102);
        step();
        redirect = 1'b0;
        repeat (3) step();

        // Reset asserted while the request for 0x10 is outstanding
        lat_fix = 1;
        do_reset();
        c0 = cyc;
        expect_at(c0 + 9, K_REQ, 1);    expect_at(c0 + 9, K_ADDR, 32'h10);
        expect_at(c0 + 10, K_REQ, 0);   expect_at(c0 + 10, K_VLD, 0);
        expect_at(c0 + 10, K_INSTR, 32'h13); expect_at(c0 + 10, K_PC, 32'h0);
        expect_at(c0 + 10, K_ADDR, RESET_PC);
        expect_at(c0 + 11, K_REQ, 1);   expect_at(c0 + 11, K_ADDR, RESET_PC);
        repeat (9) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) step();

        // Random traffic: random stalls, redirects (incl. unaligned and near the wrap point), random latency
        lat_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step();
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 2))
                    0:       t = 32'($urandom_range(0, 255)) << 2;
                    1:       t = $urandom;
                    default: t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                endcase
                issue_redirect(t);
            end else begin
                redirect = 1'b0;
            end
        end
        step();
        stall    = 1'b0;
        redirect = 1'b0;
        repeat (6) step();

        check("forward_progress", {31'h0, (consumed > 200)}, 32'h1);
        check("expectations_drained", eq.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
